// File: rtl/seq2_fetch_pkg.sv
// Shared types and constants for the Seq2 instruction fetch / program store.
package seq2_fetch_pkg;

  localparam int unsigned SF_DEPTH = 256;
  localparam int unsigned SF_AW    = 8;
  localparam int unsigned SF_IW    = 20;

  // Code F is illegal in Seq2, so fetching past the program traps the core.
  localparam logic [SF_IW-1:0] SF_BAD_INST = 20'hF0000;

  typedef enum logic [1:0] {
    SF_IDLE = 2'd0,
    SF_LOAD = 2'd1,
    SF_RUN  = 2'd2
  } sf_state_t;

  typedef logic [1:0] sf_byte_idx_t;

  localparam sf_byte_idx_t SF_BYTE0 = 2'd0;
  localparam sf_byte_idx_t SF_BYTE1 = 2'd1;
  localparam sf_byte_idx_t SF_BYTE2 = 2'd2;

endpackage

// File: rtl/seq2_fetch_if.sv
// Load port plus fetch port between the program source, Seq2 and seq2_fetch.
interface seq2_fetch_if;
  import seq2_fetch_pkg::*;

  logic                 ld_start;
  logic                 ld_valid;
  logic [7:0]           ld_data;
  logic                 ld_done;
  logic [SF_AW-1:0]     addr;
  logic [SF_IW-1:0]     inst;
  logic                 inst_en;

  modport master (
    output ld_start, ld_valid, ld_data, ld_done, addr,
    input  inst, inst_en
  );

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_done, addr,
    output inst, inst_en
  );

endinterface

// File: rtl/seq2_prog_ram.sv
// Program store: one write port, registered read port, no reset on contents.
module seq2_prog_ram
  import seq2_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = SF_DEPTH,
  parameter int unsigned WIDTH = SF_IW
) (
  input  logic             clock,
  input  logic             we,
  input  logic [SF_AW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [SF_AW-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/seq2_fetch.sv
// Seq2 fetch front end: byte-serial program load, 1-cycle fetch, and the core
// reset that holds Seq2 until a complete program is present.
module seq2_fetch
  import seq2_fetch_pkg::*;
#(
  parameter int unsigned      DEPTH    = SF_DEPTH,
  parameter logic [SF_IW-1:0] BAD_INST = SF_BAD_INST
) (
  input  logic         clock,
  input  logic         reset,
  seq2_fetch_if.slave  bus,
  output logic         core_reset,
  output logic         running,
  output logic         load_err,
  output logic [8:0]   words
);

  localparam logic [8:0] WORDS_FULL = 9'(DEPTH);

  sf_state_t        state, state_nx;
  sf_byte_idx_t     bcnt, bcnt_after;
  logic [8:0]       words_after;
  logic             byte_take, byte_drop, wr_en, done_err;
  logic [3:0]       hi_q;
  logic [7:0]       mid_q;
  logic [SF_AW-1:0] wr_ptr;
  logic [SF_AW-1:0] addr_q;
  logic             bad_q;
  logic             fetch_valid;
  logic [SF_IW-1:0] ram_rdata;

  // Words are written densely from 0, so the write pointer is the low bits of words.
  assign wr_ptr = words[SF_AW-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= SF_IDLE;
      running    <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      state      <= state_nx;
      running    <= (state_nx == SF_RUN);
      core_reset <= (state_nx != SF_RUN);
    end
  end

  always_comb begin
    state_nx = state;
    if (bus.ld_start) begin
      state_nx = SF_LOAD;
    end else if (state == SF_LOAD && bus.ld_done) begin
      state_nx = (words_after != '0) ? SF_RUN : SF_IDLE;
    end
  end

  // A byte arriving with ld_done is folded in before ld_done is judged.
  always_comb begin
    byte_take   = 1'b0;
    byte_drop   = 1'b0;
    wr_en       = 1'b0;
    done_err    = 1'b0;
    bcnt_after  = bcnt;
    words_after = words;
    if (state == SF_LOAD && !bus.ld_start) begin
      if (bus.ld_valid) begin
        if (words == WORDS_FULL) begin
          byte_drop = 1'b1;
        end else begin
          byte_take = 1'b1;
          if (bcnt == SF_BYTE2) begin
            wr_en       = 1'b1;
            bcnt_after  = SF_BYTE0;
            words_after = words + 9'd1;
          end else begin
            bcnt_after = bcnt + 2'd1;
          end
        end
      end
      if (bus.ld_done) begin
        done_err = (bcnt_after != SF_BYTE0) || (words_after == '0);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bcnt     <= SF_BYTE0;
      words    <= '0;
      load_err <= 1'b0;
      hi_q     <= '0;
      mid_q    <= '0;
    end else if (bus.ld_start) begin
      bcnt     <= SF_BYTE0;
      words    <= '0;
      load_err <= 1'b0;
    end else if (state == SF_LOAD) begin
      bcnt  <= bus.ld_done ? SF_BYTE0 : bcnt_after;
      words <= words_after;
      if (byte_drop || done_err) begin
        load_err <= 1'b1;
      end
      if (byte_take && bcnt == SF_BYTE0) begin
        hi_q <= bus.ld_data[3:0];
      end
      if (byte_take && bcnt == SF_BYTE1) begin
        mid_q <= bus.ld_data;
      end
    end
  end

  seq2_prog_ram #(
    .DEPTH (DEPTH),
    .WIDTH (SF_IW)
  ) u_ram (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({hi_q, mid_q, bus.ld_data}),
    .raddr (bus.addr),
    .rdata (ram_rdata)
  );

  // fetch_valid marks that the RAM output was read while already in RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      bad_q       <= 1'b0;
      fetch_valid <= 1'b0;
    end else begin
      addr_q      <= bus.addr;
      bad_q       <= ({1'b0, bus.addr} >= words);
      fetch_valid <= (state == SF_RUN) && (state_nx == SF_RUN);
    end
  end

  assign bus.inst    = !fetch_valid ? '0 : (bad_q ? BAD_INST : ram_rdata);
  assign bus.inst_en = running && fetch_valid && (addr_q == bus.addr);

endmodule

// File: tb/tb_seq2_fetch.sv
// Randomized scoreboard bench for seq2_fetch against a program-level model.
module tb_seq2_fetch;
  import seq2_fetch_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       core_reset, running, load_err;
  logic [8:0] words;

  seq2_fetch_if bus();

  seq2_fetch #(
    .DEPTH    (SF_DEPTH),
    .BAD_INST (SF_BAD_INST)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .core_reset (core_reset),
    .running    (running),
    .load_err   (load_err),
    .words      (words)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [19:0] exp_q[$];
  logic [7:0]  byte_q[$];
  logic [19:0] m_mem[256];
  int          m_words = 0;
  bit          m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic gen_bytes(input int nb);
    byte_q.delete();
    for (int i = 0; i < nb; i++) begin
      byte_q.push_back(8'($urandom));
    end
  endtask

  // Model: a load of nb bytes yields min(nb/3, DEPTH) words; any leftover,
  // overflow or empty program flags an error; RUN only with words present.
  task automatic do_load(input bit done_last);
    int nb;
    int nw;
    nb = byte_q.size();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    chk("start_running", 32'(running), 32'd0);
    chk("start_core_reset", 32'(core_reset), 32'd1);
    chk("start_words", 32'(words), 32'd0);
    chk("start_err", 32'(load_err), 32'd0);
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      bus.ld_valid = 1'b1;
      bus.ld_data  = byte_q[i];
      if (done_last && i == nb - 1) bus.ld_done = 1'b1;
      tick();
      bus.ld_valid = 1'b0;
      bus.ld_done  = 1'b0;
    end
    if (!(done_last && nb > 0)) begin
      bus.ld_done = 1'b1;
      tick();
      bus.ld_done = 1'b0;
    end
    nw = nb / 3;
    if (nw > int'(SF_DEPTH)) nw = int'(SF_DEPTH);
    for (int w = 0; w < nw; w++) begin
      m_mem[w] = {byte_q[3*w][3:0], byte_q[3*w+1], byte_q[3*w+2]};
    end
    m_words = nw;
    m_err   = (nb > 3 * int'(SF_DEPTH)) || (nb % 3 != 0) || (nw == 0);
    chk("load_words", 32'(words), 32'(m_words));
    chk("load_err", 32'(load_err), 32'(m_err));
    chk("load_running", 32'(running), 32'(nw > 0));
    chk("load_core_reset", 32'(core_reset), 32'(nw == 0));
  endtask

  task automatic fetch(input logic [7:0] a, input int hold);
    logic [19:0] e;
    bit          changed;
    e       = (int'(a) < m_words) ? m_mem[a] : SF_BAD_INST;
    changed = (a != bus.addr);
    exp_q.push_back(e);
    bus.addr = a;
    if (changed) begin
      @(negedge clock);
      chk("en_gap", 32'(bus.inst_en), 32'd0);
    end
    repeat (hold) tick();
  endtask

  task automatic rand_fetches(input int n);
    int          lim;
    logic [7:0]  a;
    lim = (m_words + 2 > 255) ? 255 : m_words + 2;
    for (int i = 0; i < n; i++) begin
      a = 8'($urandom_range(0, lim));
      while (a == bus.addr) a = 8'($urandom_range(0, lim));
      fetch(a, int'($urandom_range(2, 4)));
    end
  endtask

  // Monitor: each new inst_en assertion consumes one expected fetch; the word
  // must then stay put for as long as inst_en holds.
  initial begin
    logic        prev_en;
    logic [19:0] cur;
    prev_en = 1'b0;
    cur     = '0;
    forever begin
      @(negedge clock);
      if (bus.inst_en === 1'b1) begin
        if (!prev_en) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_fetch", 32'd1, 32'd0);
          end else begin
            cur = exp_q.pop_front();
          end
        end
        chk("fetch_inst", 32'(bus.inst), 32'(cur));
      end
      prev_en = (bus.inst_en === 1'b1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wait_cnt;
    reset        = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_done  = 1'b0;
    bus.addr     = '0;
    #12;
    chk("rst_inst", 32'(bus.inst), 32'd0);
    chk("rst_inst_en", 32'(bus.inst_en), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_words", 32'(words), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // IDLE ignores bytes and done
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h12;
    bus.ld_done  = 1'b1;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_done  = 1'b0;
    tick();
    chk("idle_words", 32'(words), 32'd0);
    chk("idle_running", 32'(running), 32'd0);
    chk("idle_err", 32'(load_err), 32'd0);

    // two-word program, then sequential stepping past the end
    byte_q = '{8'h01, 8'h0A, 8'h55, 8'h00, 8'h00, 8'h00};
    do_load(1'b0);
    fetch(8'd0, 2);
    fetch(8'd1, 2);
    fetch(8'd2, 2);
    fetch(8'd3, 2);
    fetch(8'd0, 3);

    // partial word discarded, then an empty load
    gen_bytes(4);
    do_load(1'(($urandom_range(0, 1))));
    fetch(8'd1, 2);
    fetch(8'd0, 2);
    byte_q.delete();
    do_load(1'b0);
    repeat (3) tick();
    chk("empty_core_reset", 32'(core_reset), 32'd1);
    chk("empty_running", 32'(running), 32'd0);

    // 257 words: last word dropped
    gen_bytes(771);
    do_load(1'(($urandom_range(0, 1))));
    fetch(8'd255, 2);
    fetch(8'd0, 3);
    rand_fetches(4);

    // abort from RUN and reload one word
    gen_bytes(3);
    do_load(1'b1);
    fetch(8'd0, 2);
    fetch(8'd1, 2);

    for (int it = 0; it < 8; it++) begin
      gen_bytes(int'($urandom_range(0, 15)));
      do_load(1'(($urandom_range(0, 1))));
      if (m_words > 0) rand_fetches(5);
    end

    // async reset mid-load, at byte1 of the third word
    gen_bytes(8);
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = byte_q[i];
      tick();
    end
    bus.ld_valid = 1'b0;
    chk("midload_words", 32'(words), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_inst", 32'(bus.inst), 32'd0);
    chk("arst_inst_en", 32'(bus.inst_en), 32'd0);
    chk("arst_core_reset", 32'(core_reset), 32'd1);
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_load_err", 32'(load_err), 32'd0);
    chk("arst_words", 32'(words), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'(i + 1);
      tick();
    end
    bus.ld_valid = 1'b0;
    bus.ld_done  = 1'b1;
    tick();
    bus.ld_done = 1'b0;
    tick();
    chk("post_rst_words", 32'(words), 32'd0);
    chk("post_rst_running", 32'(running), 32'd0);
    chk("post_rst_core_reset", 32'(core_reset), 32'd1);
    chk("post_rst_err", 32'(load_err), 32'd0);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      @(negedge clock);
      wait_cnt++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
